mem_byte_port: RTL and testbench

Request-side bus unit driving the 64 x 8 single-port `RAM` on behalf of the processor datapath. It accepts byte or 16-bit word read/write requests over a valid/ready handshake. It sequences them into byte-wide RAM cycles on `Data`/`Addr`/`we`, storing words little-endian. It returns read data and a completion pulse for every request, and is the initiator counterpart to the RAM responder.

---
 rtl/mem_byte_port.sv | 127 ++++++++++++
 tb/tb_mem_byte_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_port.sv
// Byte/word request port for a byte-wide single-port RAM: splits 16-bit accesses into little-endian byte cycles.
// Latency (accept edge = cycle 0): byte wr 2, word wr 3, byte rd 3, word rd 5; req_ready only in IDLE, no pipelining.
module mem_byte_port #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_word,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic [DATA_W-1:0]     ram_data,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_q
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO_A, RD_LO_C, RD_HI_A, RD_HI_C, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     whi_q, whi_d;
  logic                  word_q, word_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]     ram_data_q, ram_data_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     addr_inc;

  // Wraps modulo 2^ADDR_W, so a word at the top address pairs with byte 0.
  assign addr_inc = addr_q + ADDR_W'(1);

  // RAM pins are loaded on the edge that enters each state so they are flop outputs during it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    whi_d      = whi_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          whi_d      = req_wdata[2*DATA_W-1:DATA_W];
          word_d     = req_word;
          ram_addr_d = req_addr;
          if (req_write) begin
            ram_data_d = req_wdata[DATA_W-1:0];
            ram_we_d   = 1'b1;
            state_d    = WR_LO;
          end else begin
            state_d    = RD_LO_A;
          end
        end
      end
      WR_LO: begin
        if (word_q) begin
          ram_addr_d = addr_inc;
          ram_data_d = whi_q;
          ram_we_d   = 1'b1;
          state_d    = WR_HI;
        end else begin
          state_d    = DONE;
        end
      end
      WR_HI:   state_d = DONE;
      RD_LO_A: state_d = RD_LO_C;
      RD_LO_C: begin
        rdata_d[DATA_W-1:0] = ram_q;
        if (word_q) begin
          ram_addr_d = addr_inc;
          state_d    = RD_HI_A;
        end else begin
          rdata_d[2*DATA_W-1:DATA_W] = '0;
          state_d    = DONE;
        end
      end
      RD_HI_A: state_d = RD_HI_C;
      RD_HI_C: begin
        rdata_d[2*DATA_W-1:DATA_W] = ram_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      whi_q      <= '0;
      word_q     <= 1'b0;
      rdata_q    <= '0;
      ram_data_q <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      whi_q      <= whi_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign ram_data  = ram_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_byte_port.sv
// Bench for mem_byte_port: directed plan plus random byte/word traffic against a shadow-array model of the RAM.
module tb_mem_byte_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_word;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  ram_data;
  logic [5:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_q;

  logic [7:0]  mem [64];
  logic [7:0]  ref_mem [64];
  logic [15:0] exp_rdata;
  int          tests = 0;
  int          fails = 0;

  mem_byte_port #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Registered-read RAM responder.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from an idle DUT, aligned #1 after a rising edge; returns aligned in IDLE.
  task automatic do_req(input logic wr, input logic wd, input logic [5:0] a, input logic [15:0] d);
    int          cyc, lat, wecnt, exp_lat;
    logic        got, ready_bad;
    logic [5:0]  a1, we_addr[2];
    logic [7:0]  we_data[2];
    logic [15:0] rd_seen;
    a1 = a + 6'd1;
    req_write = wr; req_word = wd; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 16'(~d);
    req_addr  = ~a;
    cyc = 1; lat = 0; wecnt = 0; got = 1'b0; ready_bad = 1'b0; rd_seen = '0;
    we_addr[0] = '0; we_addr[1] = '0; we_data[0] = '0; we_data[1] = '0;
    while (!got && cyc < 20) begin
      if (rsp_valid) begin
        got = 1'b1; lat = cyc; rd_seen = rsp_rdata;
      end else if (req_ready) begin
        ready_bad = 1'b1;
      end
      if (ram_we) begin
        if (wecnt < 2) begin we_addr[wecnt] = ram_addr; we_data[wecnt] = ram_data; end
        wecnt++;
      end
      if (!got) begin @(posedge clk); #1; cyc++; end
    end
    exp_lat = wr ? (wd ? 3 : 2) : (wd ? 5 : 3);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_ready_low", 32'(ready_bad), 32'd0);
    check("we_cycles", 32'(wecnt), wr ? (wd ? 32'd2 : 32'd1) : 32'd0);
    if (wr) begin
      check("wr_lo_addr", 32'(we_addr[0]), 32'(a));
      check("wr_lo_data", 32'(we_data[0]), 32'(d[7:0]));
      if (wd) begin
        check("wr_hi_addr", 32'(we_addr[1]), 32'(a1));
        check("wr_hi_data", 32'(we_data[1]), 32'(d[15:8]));
      end
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[a1] = d[15:8];
    end else begin
      exp_rdata = {wd ? ref_mem[a1] : 8'h00, ref_mem[a]};
    end
    check("rsp_rdata", 32'(rd_seen), 32'(exp_rdata));
    @(posedge clk); #1;
    check("ready_after", 32'(req_ready), 32'd1);
    check("rdata_hold", 32'(rsp_rdata), 32'(exp_rdata));
  endtask

  initial begin
    logic [5:0] rv_ready, rv_valid;
    logic [7:0] old21;
    logic       saw;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; exp_rdata = '0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill every RAM byte so the model knows the whole array.
    for (int i = 0; i < 64; i++) do_req(1'b1, 1'b0, 6'(i), 16'($urandom));

    // Directed plan.
    do_req(1'b1, 1'b0, 6'd5, 16'h00A5);
    do_req(1'b0, 1'b0, 6'd5, 16'h0);
    check("byte_rd_5", 32'(rsp_rdata), 32'h00A5);
    do_req(1'b1, 1'b1, 6'd10, 16'h3C7E);
    check("ram10", 32'(mem[10]), 32'h7E);
    check("ram11", 32'(mem[11]), 32'h3C);
    do_req(1'b0, 1'b1, 6'd10, 16'h0);
    check("word_rd_10", 32'(rsp_rdata), 32'h3C7E);
    do_req(1'b0, 1'b0, 6'd5, 16'h0);
    check("zero_extend", 32'(rsp_rdata), 32'h00A5);
    do_req(1'b1, 1'b1, 6'd63, 16'hBEEF);
    check("ram63", 32'(mem[63]), 32'hEF);
    check("ram0", 32'(mem[0]), 32'hBE);
    do_req(1'b0, 1'b1, 6'd63, 16'h0);
    check("word_rd_63", 32'(rsp_rdata), 32'hBEEF);

    // Back-to-back: valid held across the first DONE.
    req_write = 1'b1; req_word = 1'b0; req_addr = 6'd1; req_wdata = 16'h0011; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 6'd2; req_wdata = 16'h0022;
    rv_ready = '0; rv_valid = '0;
    for (int c = 0; c < 6; c++) begin
      rv_ready[c] = req_ready;
      rv_valid[c] = rsp_valid;
      if (c == 3) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_ready_seq", 32'(rv_ready), 32'b100100);
    check("b2b_valid_seq", 32'(rv_valid), 32'b010010);
    ref_mem[1] = 8'h11; ref_mem[2] = 8'h22;
    check("b2b_ram1", 32'(mem[1]), 32'h11);
    check("b2b_ram2", 32'(mem[2]), 32'h22);

    // Reset during the high-byte cycle of a word write.
    old21 = ref_mem[21];
    req_write = 1'b1; req_word = 1'b1; req_addr = 6'd20; req_wdata = 16'h1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_wrlo_we", 32'(ram_we), 32'd1);
    @(posedge clk); #1;
    check("mid_wrhi_addr", 32'(ram_addr), 32'd21);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_data", 32'(ram_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_no_rsp", 32'(saw), 32'd0);
    check("mid_ready_after", 32'(req_ready), 32'd1);
    ref_mem[20] = 8'h34;
    exp_rdata = '0;
    check("mid_ram20", 32'(mem[20]), 32'h34);
    check("mid_ram21", 32'(mem[21]), 32'(old21));
    do_req(1'b0, 1'b1, 6'd20, 16'h0);

    // Random traffic with idle gaps.
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 64; i++) check("final_ram", 32'(mem[i]), 32'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
